tqvp_multipad_poller: RTL and testbench
=======================================

Name: tqvp_multipad_poller

Overview:
- TinyQV byte peripheral that polls up to NUM_PADS NES/SNES controllers autonomously.
- All pads share one latch line and one clock line; each pad has its own data line.
- Per-frame results are committed atomically to CPU-readable registers, with per-pad change flags and an interrupt.
- Successor to the fixed single-NES/SNES reader: generalised in pad count, frame length (8/16 bits), timing and poll rate, and adds one-shot polling, change detection and IRQ.

Parameters:
- NUM_PADS, 2, number of controller data inputs (1..4).
- CLK_DIV, 384, half-period of pad_clk in clk cycles (6 us at 64 MHz); >=2.
- POLL_PERIOD, 1066667, clk cycles between automatic frames (60 Hz at 64 MHz); must exceed worst-case frame length.

Ports:
- clk  in  1  system clock (64 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- pad_data  in  NUM_PADS  controller serial data, active-low, already 2-flop synchronised upstream.
- pad_latch  out  1  shared latch strobe, active-high.
- pad_clk  out  1  shared shift clock; idles high.
- address  in  4  register address.
- data_write  in  1  single-cycle write strobe.
- data_in  in  8  write data, valid with data_write.
- data_out  out  8  read data, combinational from address.
- user_interrupt  out  1  level IRQ = irq_en & (|changed).

Behaviour:
- Reset (async, rst_n low): FSM to IDLE, pad_latch=0, pad_clk=1, all registers and poll timer=0, user_interrupt=0. Reset mid-frame abandons the frame; no commit.
- Register map:
  - 0x0 CTRL R/W: bit0 enable, bit1 mode (0 = NES 8 bits, 1 = SNES 16 bits), bit2 irq_en. Other bits read 0.
  - 0x1 STATUS: bit0 busy (R); bit1 frame_done (sticky, W1C).
  - 0x2+2p / 0x3+2p: pad p buttons [7:0] / [15:8], read-only. High byte is 0 in NES mode. Unimplemented pads read 0.
  - 0xA CHANGED: bits[NUM_PADS-1:0] sticky, W1C.
  - 0xB: any write requests a one-shot frame.
  - All other addresses read 0; writes ignored.
- Poll timer:
  - Counts while enable=1; tick and wrap at POLL_PERIOD-1.
  - Cleared and held while enable=0.
  - Tick or one-shot starts a frame only in IDLE; ignored while busy.
  - One-shot works regardless of enable.
- Frame start: mode sampled into nbits (8/16) and held for the whole frame; CTRL writes mid-frame affect the next frame only.
- FSM sequence:
  - IDLE -> LATCH: pad_latch=1, pad_clk=1 for 2*CLK_DIV cycles.
  - CLK_HI: latch=0, clk=1 for CLK_DIV cycles. On its last cycle sample bit[idx] = ~pad_data[p] for all pads into shadow registers.
  - If idx==nbits-1 -> COMMIT, else CLK_LO.
  - CLK_LO: clk=0 for CLK_DIV cycles, then idx++ and -> CLK_HI.
  - COMMIT (1 cycle): copy shadows to visible registers, set frame_done, update changed -> IDLE.
- Frame length: 2D + nbits*D + (nbits-1)*D + 1 cycles (D=CLK_DIV). busy=1 from first LATCH cycle through COMMIT.
- Bit order: bit0 = first bit shifted out by the controller (NES: A,B,Sel,Start,U,D,L,R; SNES: B,Y,Sel,Start,U,D,L,R,A,X,L,R,4 fixed).
- Change detection: changed[p] set at COMMIT if the new 16-bit value != the previous committed value. A disconnected (pulled-up) pad reads all 0.
- Same-cycle set and W1C on a sticky flag: set wins.
- Clearing enable mid-frame lets the current frame complete.
- No arithmetic wrap beyond the counters: idx is 4 bits; the divider and poll counters are sized by $clog2 of their parameters.

Decomposition:
- Package tqvp_multipad_pkg: FSM state enum (IDLE, LATCH, CLK_HI, CLK_LO, COMMIT), register address constants, CTRL/STATUS bit indices, NES_BITS=8, SNES_BITS=16.
- Sub-module tqvp_multipad_seq: FSM, divider, bit index and shadow shift registers; outputs pad_latch, pad_clk, busy, a commit pulse and shadow data.
- Top level owns the poll timer, register file, sticky flags, read mux and IRQ.

Test Plan (bench uses CLK_DIV=4, POLL_PERIOD=200, NUM_PADS=2):
- Reset, then read 0x0..0xB -> all 0x00; pad_clk=1, pad_latch=0, user_interrupt=0.
- Write 0xB in NES mode; pad0 drives A,Start pressed, pad1 idle -> busy for 69 cycles; 0x2=0x09, 0x3=0x00, 0x4=0x00; STATUS=0x02; CHANGED=0x01.
- SNES mode, CTRL=0x07, pad1 presses X and R (bits 9, 11) -> frame of 133 cycles every 200; 0x5=0x0A; IRQ rises at COMMIT; write 0x01 to 0xA -> IRQ still high (pad0 flag clear, pad1 set); write 0x02 -> IRQ low.
- Identical buttons on consecutive frames -> CHANGED stays 0, frame_done re-sets each frame; W1C coinciding with COMMIT -> flag remains 1.
- Toggle mode during CLK_LO of an NES frame -> that frame still ends after 8 bits; the next frame is 16 bits.
- Assert rst_n mid-CLK_LO -> pad_clk=1 and pad_latch=0 immediately; visible registers stay 0x00 after release; no IRQ.

Source files
------------

// File: rtl/tqvp_multipad_pkg.sv
// Shared types and constants for the multi-pad NES/SNES poller.
// Holds the sequencer state encoding, register addresses and bit positions.
package tqvp_multipad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_HI,
    CLK_LO,
    COMMIT
  } seq_state_t;

  localparam int MAX_PADS  = 4;
  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;
  localparam int CTRL_W    = 3;

  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_STATUS   = 4'h1;
  localparam logic [3:0] ADDR_PAD_BASE = 4'h2;
  localparam logic [3:0] ADDR_CHANGED  = 4'hA;
  localparam logic [3:0] ADDR_ONESHOT  = 4'hB;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  // Index of the final bit shifted in for the selected controller type.
  function automatic logic [3:0] last_bit_idx(input logic snes_mode);
    return snes_mode ? 4'(SNES_BITS - 1) : 4'(NES_BITS - 1);
  endfunction

endpackage

// File: rtl/tqvp_multipad_poller_if.sv
// CPU-side byte register bus of the poller: address, write strobe, data and IRQ.
// The CPU drives through master, the peripheral answers through slave.
interface tqvp_multipad_poller_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       user_interrupt;

  modport master (
    output address, data_write, data_in,
    input  data_out, user_interrupt
  );

  modport slave (
    input  address, data_write, data_in,
    output data_out, user_interrupt
  );
endinterface

// File: rtl/tqvp_multipad_seq.sv
// Frame sequencer: drives the shared latch/clock lines and shifts every pad's
// serial data into shadow registers, then pulses commit for one cycle.
module tqvp_multipad_seq
  import tqvp_multipad_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int CLK_DIV  = 384
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic [NUM_PADS-1:0]        pad_data,
  output logic                       pad_latch,
  output logic                       pad_clk,
  output logic                       busy,
  output logic                       commit,
  output logic [NUM_PADS-1:0][15:0]  shadow
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);

  seq_state_t                state_q, state_d;
  logic [DW-1:0]             div_q, div_d;
  logic [3:0]                idx_q, idx_d;
  logic [3:0]                last_idx_q, last_idx_d;
  logic [NUM_PADS-1:0][15:0] shadow_q, shadow_d;
  logic                      latch_q, latch_d;
  logic                      sclk_q, sclk_d;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q + 1'b1;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    shadow_d   = shadow_q;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          state_d    = LATCH;
          idx_d      = '0;
          last_idx_d = last_bit_idx(mode);
          // Cleared so the unused high byte reads 0 after an NES frame.
          shadow_d   = '0;
        end
      end
      LATCH: begin
        if (div_q == LATCH_LAST) begin
          state_d = CLK_HI;
          div_d   = '0;
        end
      end
      CLK_HI: begin
        if (div_q == HALF_LAST) begin
          div_d = '0;
          for (int p = 0; p < NUM_PADS; p++) begin
            shadow_d[p][idx_q] = ~pad_data[p];
          end
          state_d = (idx_q == last_idx_q) ? COMMIT : CLK_LO;
        end
      end
      CLK_LO: begin
        if (div_q == HALF_LAST) begin
          div_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = CLK_HI;
        end
      end
      COMMIT: begin
        div_d   = '0;
        state_d = IDLE;
      end
      default: begin
        div_d   = '0;
        state_d = IDLE;
      end
    endcase
    latch_d = (state_d == LATCH);
    sclk_d  = (state_d != CLK_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      shadow_q   <= '0;
      latch_q    <= 1'b0;
      sclk_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      shadow_q   <= shadow_d;
      latch_q    <= latch_d;
      sclk_q     <= sclk_d;
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = sclk_q;
  assign busy      = (state_q != IDLE);
  assign commit    = (state_q == COMMIT);
  assign shadow    = shadow_q;

endmodule

// File: rtl/tqvp_multipad_poller.sv
// TinyQV byte peripheral polling up to four NES/SNES pads on a shared latch/clock.
// Owns the poll timer, CPU register file, sticky flags and interrupt.
module tqvp_multipad_poller
  import tqvp_multipad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int CLK_DIV     = 384,
  parameter int POLL_PERIOD = 1066667
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PADS-1:0]   pad_data,
  output logic                  pad_latch,
  output logic                  pad_clk,
  tqvp_multipad_poller_if.slave bus
);
  localparam int PW = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

  logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
  logic                      frame_done_q, frame_done_d;
  logic [NUM_PADS-1:0]       changed_q, changed_d;
  logic [NUM_PADS-1:0][15:0] btn_q, btn_d;
  logic [PW-1:0]             poll_q, poll_d;

  logic                      busy, commit, poll_tick, oneshot, start;
  logic                      wr_ctrl, wr_status, wr_changed;
  logic [NUM_PADS-1:0][15:0] shadow;
  logic [2*MAX_PADS-1:0][7:0] pad_byte;
  logic [3:0]                pad_off;
  logic [7:0]                rdata;
  logic                      unused_bits;

  assign wr_ctrl    = bus.data_write && (bus.address == ADDR_CTRL);
  assign wr_status  = bus.data_write && (bus.address == ADDR_STATUS);
  assign wr_changed = bus.data_write && (bus.address == ADDR_CHANGED);
  assign oneshot    = bus.data_write && (bus.address == ADDR_ONESHOT);
  assign poll_tick  = ctrl_q[CTRL_ENABLE] && (poll_q == POLL_LAST);
  // The sequencer only honours start in IDLE, so requests while busy are dropped.
  assign start      = poll_tick || oneshot;

  tqvp_multipad_seq #(
    .NUM_PADS (NUM_PADS),
    .CLK_DIV  (CLK_DIV)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (ctrl_q[CTRL_MODE]),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .busy      (busy),
    .commit    (commit),
    .shadow    (shadow)
  );

  always_comb begin
    ctrl_d = wr_ctrl ? bus.data_in[CTRL_W-1:0] : ctrl_q;
    poll_d = (!ctrl_q[CTRL_ENABLE] || poll_tick) ? '0 : poll_q + 1'b1;
    btn_d  = commit ? shadow : btn_q;
    // Sticky flags: a set in the same cycle as a write-one-to-clear wins.
    frame_done_d = (frame_done_q && !(wr_status && bus.data_in[STATUS_DONE])) || commit;
    for (int p = 0; p < NUM_PADS; p++) begin
      changed_d[p] = (changed_q[p] && !(wr_changed && bus.data_in[p]))
                   || (commit && (shadow[p] != btn_q[p]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      frame_done_q <= 1'b0;
      changed_q    <= '0;
      btn_q        <= '0;
      poll_q       <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      frame_done_q <= frame_done_d;
      changed_q    <= changed_d;
      btn_q        <= btn_d;
      poll_q       <= poll_d;
    end
  end

  for (genvar gi = 0; gi < MAX_PADS; gi++) begin : g_pad_bytes
    if (gi < NUM_PADS) begin : g_present
      assign pad_byte[2*gi]   = btn_q[gi][7:0];
      assign pad_byte[2*gi+1] = btn_q[gi][15:8];
    end else begin : g_absent
      assign pad_byte[2*gi]   = 8'h00;
      assign pad_byte[2*gi+1] = 8'h00;
    end
  end

  assign pad_off = bus.address - ADDR_PAD_BASE;

  always_comb begin
    rdata = 8'h00;
    case (bus.address)
      ADDR_CTRL:    rdata = 8'(ctrl_q);
      ADDR_STATUS:  rdata = {6'b0, frame_done_q, busy};
      ADDR_CHANGED: rdata = 8'(changed_q);
      default: begin
        if (bus.address >= ADDR_PAD_BASE && bus.address < ADDR_CHANGED) begin
          rdata = pad_byte[pad_off[2:0]];
        end
      end
    endcase
  end

  assign bus.data_out       = rdata;
  assign bus.user_interrupt = ctrl_q[CTRL_IRQ_EN] && (|changed_q);
  assign unused_bits        = ^{bus.data_in[7:CTRL_W], pad_off[3]};

endmodule

// File: tb/tb_tqvp_multipad_poller.sv
// Bench for tqvp_multipad_poller: behavioural shift-register pads, a frame
// scoreboard filled when a frame is armed and drained when busy drops.
module tb_tqvp_multipad_poller;
  import tqvp_multipad_pkg::*;

  localparam int NP  = 2;
  localparam int D   = 4;
  localparam int PER = 200;

  typedef struct {
    int          len;
    logic [15:0] p0;
    logic [15:0] p1;
    logic [1:0]  chg;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [NP-1:0] pad_data;
  logic          pad_latch;
  logic          pad_clk;
  tqvp_multipad_poller_if bus_if();

  tqvp_multipad_poller #(
    .NUM_PADS    (NP),
    .CLK_DIV     (D),
    .POLL_PERIOD (PER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .bus       (bus_if)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          frame_no     = 0;
  int          shift_pos    = 0;
  logic [15:0] pad_btn [NP];
  logic [15:0] mdl_btn [NP];
  logic [1:0]  mdl_chg;
  exp_t        sb_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: latch reloads bit 0, each rising pad_clk exposes the next bit.
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) shift_pos <= 0;
    else           shift_pos <= shift_pos + 1;
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      pad_data[p] = (shift_pos < 16) ? ~pad_btn[p][shift_pos[3:0]] : 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus_if.address    = a;
    bus_if.data_in    = d;
    bus_if.data_write = 1'b1;
    @(negedge clk);
    bus_if.data_write = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus_if.address    = a;
    bus_if.data_write = 1'b0;
    #1;
    check_val(tag, 32'(bus_if.data_out), 32'(exp));
    @(negedge clk);
  endtask

  task automatic wait_busy(input logic want, input int bound, output int at_cyc);
    bus_if.address    = ADDR_STATUS;
    bus_if.data_write = 1'b0;
    for (int i = 0; i < bound; i++) begin
      #1;
      if (bus_if.data_out[STATUS_BUSY] == want) begin
        at_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
    check_val("busy_wait_timeout", 32'(bus_if.data_out[STATUS_BUSY]), 32'(want));
    at_cyc = cyc;
  endtask

  task automatic wait_pad_clk_low(input int bound);
    for (int i = 0; i < bound; i++) begin
      #1;
      if (pad_clk == 1'b0) return;
      @(negedge clk);
    end
    check_val("pad_clk_low_timeout", 32'(pad_clk), 32'd0);
  endtask

  task automatic push_frame(input logic snes);
    exp_t        e;
    logic [15:0] mask;
    logic [15:0] v;
    int          nb;
    mask = snes ? 16'hFFFF : 16'h00FF;
    nb   = snes ? 16 : 8;
    for (int p = 0; p < NP; p++) begin
      v = pad_btn[p] & mask;
      if (v != mdl_btn[p]) mdl_chg[p] = 1'b1;
      mdl_btn[p] = v;
    end
    e.len = 2*D + nb*D + (nb-1)*D + 1;
    e.p0  = mdl_btn[0];
    e.p1  = mdl_btn[1];
    e.chg = mdl_chg;
    sb_q.push_back(e);
  endtask

  task automatic finish_frame(input int rise, input int fall);
    exp_t e;
    frame_no++;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    $display("[TB] frame %0d len=%0d pad0=%04h pad1=%04h changed=%02b",
             frame_no, fall - rise, e.p0, e.p1, e.chg);
    check_val("frame_len",  32'(fall - rise), 32'(e.len));
    check_reg("pad0_lo",    ADDR_PAD_BASE,        e.p0[7:0]);
    check_reg("pad0_hi",    ADDR_PAD_BASE + 4'd1, e.p0[15:8]);
    check_reg("pad1_lo",    ADDR_PAD_BASE + 4'd2, e.p1[7:0]);
    check_reg("pad1_hi",    ADDR_PAD_BASE + 4'd3, e.p1[15:8]);
    check_reg("changed",    ADDR_CHANGED,         8'(e.chg));
    check_reg("status_done", ADDR_STATUS,         8'h02);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 12; a++) begin
      check_reg(tag, 4'(a), 8'h00);
    end
  endtask

  initial begin
    int r1, r2, r3, r4, f;
    pad_btn[0] = 16'h0000;
    pad_btn[1] = 16'h0000;
    for (int p = 0; p < NP; p++) mdl_btn[p] = 16'h0000;
    mdl_chg           = 2'b00;
    rst_n             = 1'b0;
    bus_if.address    = 4'h0;
    bus_if.data_in    = 8'h00;
    bus_if.data_write = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_pad_clk",   32'(pad_clk),   32'd1);
    check_val("rst_pad_latch", 32'(pad_latch), 32'd0);
    check_val("rst_irq",       32'(bus_if.user_interrupt), 32'd0);
    check_all_zero("rst_reg");

    // NES one-shot: pad0 A+Start
    pad_btn[0] = 16'h0009;
    push_frame(1'b0);
    bus_write(ADDR_ONESHOT, 8'h00);
    wait_busy(1'b1, 50, r1);
    wait_busy(1'b0, 400, f);
    finish_frame(r1, f);
    check_val("nes_irq_off", 32'(bus_if.user_interrupt), 32'd0);
    bus_write(ADDR_STATUS, 8'h02);
    bus_write(ADDR_CHANGED, 8'h03);
    mdl_chg = 2'b00;
    check_reg("clr_status",  ADDR_STATUS,  8'h00);
    check_reg("clr_changed", ADDR_CHANGED, 8'h00);

    // SNES auto polling with IRQ: pad0 adds A, pad1 presses X and R
    pad_btn[0] = 16'h0109;
    pad_btn[1] = 16'h0A00;
    push_frame(1'b1);
    bus_write(ADDR_CTRL, 8'h07);
    check_val("snes_irq_before", 32'(bus_if.user_interrupt), 32'd0);
    check_reg("ctrl_rd", ADDR_CTRL, 8'h07);
    wait_busy(1'b1, 400, r2);
    wait_busy(1'b0, 400, f);
    check_val("snes_irq_commit", 32'(bus_if.user_interrupt), 32'd1);
    finish_frame(r2, f);
    bus_write(ADDR_CHANGED, 8'h01);
    mdl_chg[0] = 1'b0;
    check_val("irq_after_w1c0", 32'(bus_if.user_interrupt), 32'd1);
    check_reg("changed_after_w1c0", ADDR_CHANGED, 8'h02);
    bus_write(ADDR_CHANGED, 8'h02);
    mdl_chg[1] = 1'b0;
    check_val("irq_after_w1c1", 32'(bus_if.user_interrupt), 32'd0);
    bus_write(ADDR_STATUS, 8'h02);
    check_reg("status_cleared", ADDR_STATUS, 8'h00);

    // Identical frame; W1C of frame_done lands on the commit edge
    push_frame(1'b1);
    wait_busy(1'b1, 400, r3);
    check_val("poll_period_a", 32'(r3 - r2), 32'(PER));
    repeat (132) @(negedge clk);
    bus_write(ADDR_STATUS, 8'h02);
    wait_busy(1'b0, 50, f);
    finish_frame(r3, f);

    // Changed frame; W1C of changed[0] lands on the commit edge
    pad_btn[0] = 16'h0001;
    push_frame(1'b1);
    wait_busy(1'b1, 400, r4);
    check_val("poll_period_b", 32'(r4 - r3), 32'(PER));
    repeat (132) @(negedge clk);
    bus_write(ADDR_CHANGED, 8'h01);
    wait_busy(1'b0, 50, f);
    check_val("irq_set_wins", 32'(bus_if.user_interrupt), 32'd1);
    finish_frame(r4, f);
    bus_write(ADDR_CTRL, 8'h00);
    check_val("irq_disabled", 32'(bus_if.user_interrupt), 32'd0);
    bus_write(ADDR_CHANGED, 8'h03);
    mdl_chg = 2'b00;

    // Mode switched to SNES during CLK_LO of an NES frame
    pad_btn[0] = 16'hFF81;
    push_frame(1'b0);
    bus_write(ADDR_ONESHOT, 8'h00);
    wait_busy(1'b1, 50, r1);
    wait_pad_clk_low(50);
    bus_write(ADDR_CTRL, 8'h02);
    wait_busy(1'b0, 400, f);
    finish_frame(r1, f);
    push_frame(1'b1);
    bus_write(ADDR_ONESHOT, 8'h00);
    wait_busy(1'b1, 50, r1);
    wait_busy(1'b0, 400, f);
    finish_frame(r1, f);

    // Reset in the middle of CLK_LO abandons the frame
    pad_btn[1] = 16'h00FF;
    bus_write(ADDR_ONESHOT, 8'h00);
    wait_busy(1'b1, 50, r1);
    wait_pad_clk_low(50);
    rst_n = 1'b0;
    #1;
    check_val("arst_pad_clk",   32'(pad_clk),   32'd1);
    check_val("arst_pad_latch", 32'(pad_latch), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) mdl_btn[p] = 16'h0000;
    mdl_chg = 2'b00;
    @(negedge clk);
    check_all_zero("arst_reg");
    repeat (40) @(negedge clk);
    check_reg("arst_idle_status", ADDR_STATUS, 8'h00);
    check_val("arst_irq", 32'(bus_if.user_interrupt), 32'd0);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
